// File: rtl/sd_enmux_arb_if.sv
// Link bundle for sd_enmux_arb: full-width channel sources on the c_* side,
// half-width tagged beats on the p_* side.
interface sd_enmux_arb_if #(
  parameter int width  = 8,
  parameter int inputs = 2,
  parameter int cw     = $clog2(inputs)
);
  logic [inputs-1:0]       c_srdy;
  logic [inputs-1:0]       c_drdy;
  logic [inputs*width-1:0] c_data;
  logic                    p_srdy;
  logic                    p_drdy;
  logic [width/2-1:0]      p_data;
  logic [cw-1:0]           p_chan;
  logic                    p_half;

  modport master (
    input  c_srdy, c_data, p_drdy,
    output c_drdy, p_srdy, p_data, p_chan, p_half
  );

  modport slave (
    output c_srdy, c_data, p_drdy,
    input  c_drdy, p_srdy, p_data, p_chan, p_half
  );
endinterface

// File: rtl/sd_enmux_arb.sv
// Round-robin arbiter that serialises full-width channel tokens onto a
// half-width link as upper-then-lower beats tagged with channel and half.
module sd_enmux_arb #(
  parameter int width  = 8,
  parameter int inputs = 2,
  parameter int cw     = $clog2(inputs)
) (
  input  logic           clk,
  input  logic           reset,
  sd_enmux_arb_if.master bus
);
  typedef enum logic [1:0] {s_idle, s_upper, s_lower} state_t;

  localparam int hw = width / 2;

  state_t            state, state_nxt;
  logic [cw-1:0]     gnt, gnt_nxt;
  logic [cw-1:0]     ptr, ptr_nxt;
  logic [cw-1:0]     base, win;
  logic [cw-1:0]     chan_nxt;
  logic              half_nxt;
  logic [hw-1:0]     data_nxt;
  logic              any_req;
  logic [width-1:0]  win_word, gnt_word;
  logic [inputs-1:0] drdy;
  int                idx;

  // In s_lower the search starts after gnt, which is the ptr value being
  // written this cycle, so back-to-back tokens need no extra cycle.
  always_comb begin
    base    = (state == s_lower) ? gnt : ptr;
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    // Walk the order backwards so the earliest requester is the last write.
    for (int i = inputs; i >= 1; i--) begin
      idx = (int'(base) + i) % inputs;
      if (bus.c_srdy[idx]) begin
        win     = cw'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign win_word = bus.c_data[int'(win) * width +: width];
  assign gnt_word = bus.c_data[int'(gnt) * width +: width];

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    data_nxt  = bus.p_data;
    chan_nxt  = bus.p_chan;
    half_nxt  = bus.p_half;
    drdy      = '0;
    case (state)
      s_idle: begin
        if (any_req) begin
          gnt_nxt   = win;
          data_nxt  = win_word[width-1 -: hw];
          chan_nxt  = win;
          half_nxt  = 1'b1;
          state_nxt = s_upper;
        end
      end
      s_upper: begin
        if (bus.p_drdy) begin
          drdy[gnt] = 1'b1;
          data_nxt  = gnt_word[hw-1:0];
          half_nxt  = 1'b0;
          state_nxt = s_lower;
        end
      end
      s_lower: begin
        if (bus.p_drdy) begin
          ptr_nxt = gnt;
          if (any_req) begin
            gnt_nxt   = win;
            data_nxt  = win_word[width-1 -: hw];
            chan_nxt  = win;
            half_nxt  = 1'b1;
            state_nxt = s_upper;
          end else begin
            state_nxt = s_idle;
          end
        end
      end
      default: state_nxt = s_idle;
    endcase
  end

  assign bus.c_drdy = drdy;
  assign bus.p_srdy = (state != s_idle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= s_idle;
      gnt        <= '0;
      ptr        <= cw'(inputs - 1);
      bus.p_chan <= '0;
      bus.p_half <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      ptr        <= ptr_nxt;
      bus.p_chan <= chan_nxt;
      bus.p_half <= half_nxt;
    end
  end

  // Payload is qualified by p_srdy, so it carries no reset.
  always_ff @(posedge clk) begin
    bus.p_data <= data_nxt;
  end
endmodule

// File: tb/tb_sd_enmux_arb.sv
// Bench for sd_enmux_arb: 2- and 3-input instances share one stimulus,
// a token-level model checks every cycle, directed checks pin key beats.
module tb_sd_enmux_arb;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] c_srdy;
  logic [23:0] c_data;
  logic       p_drdy;

  int n_assert = 0;
  int n_fail   = 0;
  int pcnt     = 0;
  int p0;

  always #5 clk = ~clk;

  sd_enmux_arb_if #(.width(8), .inputs(2)) b2 ();
  sd_enmux_arb_if #(.width(8), .inputs(3)) b3 ();

  assign b2.c_srdy = c_srdy[1:0];
  assign b2.c_data = c_data[15:0];
  assign b2.p_drdy = p_drdy;
  assign b3.c_srdy = c_srdy;
  assign b3.c_data = c_data;
  assign b3.p_drdy = p_drdy;

  sd_enmux_arb #(.width(8), .inputs(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  sd_enmux_arb #(.width(8), .inputs(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset  = 1'b1;
    c_srdy = 3'b000;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // First requester after p in round-robin order among n channels.
  function automatic int pick(input int n, input int p, input logic [2:0] r);
    for (int i = 1; i <= n; i++) begin
      int k;
      k = (p + i) % n;
      if (r[k]) return k;
    end
    return 0;
  endfunction

  // Token model: phase 0 = no token, 1 = upper beat on link, 2 = lower beat.
  int         mph [2] = '{0, 0};
  int         mptr[2] = '{1, 2};
  int         mch [2] = '{0, 0};
  logic [7:0] mtok[2] = '{8'h00, 8'h00};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [2:0] req;
      req = (d == 0) ? {1'b0, c_srdy[1:0]} : c_srdy;
      if (reset) begin
        mph[d] = 0; mptr[d] = d + 1; mch[d] = 0;
      end else if (mph[d] == 0) begin
        if (req != 0) begin
          mch[d] = pick(d + 2, mptr[d], req); mtok[d] = c_data[mch[d]*8 +: 8]; mph[d] = 1;
        end
      end else if (mph[d] == 1) begin
        if (p_drdy) mph[d] = 2;
      end else if (p_drdy) begin
        mptr[d] = mch[d];
        if (req != 0) begin
          mch[d] = pick(d + 2, mptr[d], req); mtok[d] = c_data[mch[d]*8 +: 8]; mph[d] = 1;
        end else mph[d] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (b2.c_drdy[1]) pcnt++;
    for (int d = 0; d < 2; d++) begin
      logic       s_a, h_a;
      logic [3:0] dat_a;
      logic [1:0] ch_a;
      logic [2:0] dr_a;
      logic [3:0] dat_e;
      if (d == 0) begin
        s_a = b2.p_srdy; h_a = b2.p_half; dat_a = b2.p_data;
        ch_a = {1'b0, b2.p_chan}; dr_a = {1'b0, b2.c_drdy};
      end else begin
        s_a = b3.p_srdy; h_a = b3.p_half; dat_a = b3.p_data;
        ch_a = b3.p_chan; dr_a = b3.c_drdy;
      end
      dat_e = (mph[d] == 1) ? mtok[d][7:4] : mtok[d][3:0];
      chk($sformatf("mdl%0d_srdy", d + 2), 32'(s_a), 32'(mph[d] != 0));
      chk($sformatf("mdl%0d_half", d + 2), 32'(h_a), 32'(mph[d] == 1));
      chk($sformatf("mdl%0d_chan", d + 2), 32'(ch_a), 32'(mch[d]));
      chk($sformatf("mdl%0d_drdy", d + 2), 32'(dr_a),
          (mph[d] == 1 && p_drdy) ? (32'd1 << mch[d]) : 32'd0);
      if (mph[d] != 0)
        chk($sformatf("mdl%0d_data", d + 2), 32'(dat_a), 32'(dat_e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  int rr_d[6] = '{1, 2, 3, 4, 1, 2};
  int rr_c[6] = '{0, 0, 1, 1, 0, 0};

  initial begin
    c_data = '0;
    p_drdy = 1'b1;
    do_reset;
    #1;
    chk("rst_srdy", 32'(b2.p_srdy), 32'd0);
    chk("rst_drdy", 32'(b2.c_drdy), 32'd0);
    chk("rst_chan", 32'(b2.p_chan), 32'd0);
    chk("rst_half", 32'(b2.p_half), 32'd0);
    chk("rst_srdy3", 32'(b3.p_srdy), 32'd0);

    // single token
    c_data = 24'h0000A5; c_srdy = 3'b001;
    tick; #1;
    chk("single_up_data", 32'(b2.p_data), 32'hA);
    chk("single_up_chan", 32'(b2.p_chan), 32'd0);
    chk("single_up_half", 32'(b2.p_half), 32'd1);
    chk("single_up_drdy", 32'(b2.c_drdy), 32'b01);
    tick; c_srdy = 3'b000; #1;
    chk("single_lo_data", 32'(b2.p_data), 32'h5);
    chk("single_lo_half", 32'(b2.p_half), 32'd0);
    chk("single_lo_drdy", 32'(b2.c_drdy), 32'd0);
    tick; #1;
    chk("single_idle", 32'(b2.p_srdy), 32'd0);

    // round robin, both always ready
    do_reset;
    c_data = 24'h003412; c_srdy = 3'b011;
    for (int i = 0; i < 6; i++) begin
      tick; #1;
      chk("rr_data", 32'(b2.p_data), 32'(rr_d[i]));
      chk("rr_chan", 32'(b2.p_chan), 32'(rr_c[i]));
      chk("rr_srdy", 32'(b2.p_srdy), 32'd1);
      chk("rr_chan3", 32'(b3.p_chan), 32'(rr_c[i]));
    end
    c_srdy = 3'b000;
    tick;

    // backpressure
    do_reset;
    c_data = 24'h00C300; c_srdy = 3'b010; p_drdy = 1'b0; p0 = pcnt;
    repeat (3) begin
      tick; #1;
      chk("bp_up_data", 32'(b2.p_data), 32'hC);
      chk("bp_up_chan", 32'(b2.p_chan), 32'd1);
      chk("bp_up_drdy", 32'(b2.c_drdy), 32'd0);
    end
    tick; p_drdy = 1'b1; #1;
    chk("bp_accept_drdy", 32'(b2.c_drdy), 32'b10);
    tick; c_srdy = 3'b000; p_drdy = 1'b0; #1;
    chk("bp_lo_data", 32'(b2.p_data), 32'h3);
    chk("bp_lo_chan", 32'(b2.p_chan), 32'd1);
    tick; #1;
    chk("bp_lo_hold", 32'(b2.p_data), 32'h3);
    chk("bp_lo_srdy", 32'(b2.p_srdy), 32'd1);
    p_drdy = 1'b1;
    tick; #1;
    chk("bp_idle", 32'(b2.p_srdy), 32'd0);
    chk("bp_pulses", 32'(pcnt - p0), 32'd1);

    // late requesters on the 3-input instance
    do_reset;
    c_data = 24'h225A11; c_srdy = 3'b010;
    tick; c_srdy = 3'b111; #1;
    chk("late_up_chan", 32'(b3.p_chan), 32'd1);
    chk("late_up_drdy", 32'(b3.c_drdy), 32'b010);
    tick; c_srdy = 3'b101; #1;
    chk("late_lo_chan", 32'(b3.p_chan), 32'd1);
    chk("late_lo_data", 32'(b3.p_data), 32'hA);
    tick; #1;
    chk("late_ch2_chan", 32'(b3.p_chan), 32'd2);
    chk("late_ch2_data", 32'(b3.p_data), 32'h2);
    tick; c_srdy = 3'b001; #1;
    chk("late_ch2_lo", 32'(b3.p_half), 32'd0);
    tick; #1;
    chk("late_ch0_chan", 32'(b3.p_chan), 32'd0);
    chk("late_ch0_data", 32'(b3.p_data), 32'h1);
    tick; c_srdy = 3'b000; #1;
    tick; #1;
    chk("late_idle", 32'(b3.p_srdy), 32'd0);

    // reset during the lower beat
    do_reset;
    c_data = 24'h006677; c_srdy = 3'b001;
    tick; #1;
    chk("rmid_up_chan", 32'(b2.p_chan), 32'd0);
    tick; c_srdy = 3'b011; reset = 1'b1; #1;
    chk("rmid_lo_drdy", 32'(b2.c_drdy), 32'd0);
    tick; #1;
    chk("rmid_srdy", 32'(b2.p_srdy), 32'd0);
    chk("rmid_drdy", 32'(b2.c_drdy), 32'd0);
    chk("rmid_srdy3", 32'(b3.p_srdy), 32'd0);
    reset = 1'b0;
    tick; #1;
    chk("rmid_first_chan", 32'(b2.p_chan), 32'd0);
    chk("rmid_first_data", 32'(b2.p_data), 32'h7);
    chk("rmid_first_chan3", 32'(b3.p_chan), 32'd0);
    tick; c_srdy = 3'b010;
    tick;
    tick; c_srdy = 3'b000;
    tick; #1;

    // idle gap
    chk("gap_idle0", 32'(b2.p_srdy), 32'd0);
    repeat (3) begin
      tick; #1;
      chk("gap_idle", 32'(b2.p_srdy), 32'd0);
    end
    c_data = 24'h009E00; c_srdy = 3'b010;
    tick; #1;
    chk("gap_up_srdy", 32'(b2.p_srdy), 32'd1);
    chk("gap_up_data", 32'(b2.p_data), 32'h9);
    chk("gap_up_chan", 32'(b2.p_chan), 32'd1);
    tick; c_srdy = 3'b000; #1;
    chk("gap_lo_data", 32'(b2.p_data), 32'hE);
    tick; #1;
    chk("gap_end", 32'(b2.p_srdy), 32'd0);

    repeat (2) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_enmux_arb.md
# sd_enmux_arb

Round-robin arbiter and sequencer that shares one half-width srdy/drdy link among `inputs` full-width token sources. It selects a requester, sends its token as two half-width beats (upper half first), and tags each beat with the source channel number and a half indicator. It sits at the transmit end of a narrow inter-block link. The receiving side pairs it with a demultiplexer that routes by `p_chan` and reassembles by `p_half`.

## Interface
- `width`, default 8: full token width. Must be even and ≥2.
- `inputs`, default 2: number of requesting channels. Must be ≥2.
- `cw`, default `$clog2(inputs)`: channel-id width. Derived; do not override.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `c_srdy`  in  `inputs`  per-channel source valid.
- `c_drdy`  out  `inputs`  per-channel consume strobe; one-hot or zero.
- `c_data`  in  `inputs*width`  channel k occupies bits `[k*width +: width]`.
- `p_srdy`  out  1  link beat valid.
- `p_drdy`  in  1  link beat accepted.
- `p_data`  out  `width/2`  current half-token.
- `p_chan`  out  `cw`  channel id of the current beat.
- `p_half`  out  1  1 = upper-half beat, 0 = lower-half beat.

## Operation
- Registered state:
  - `state` ∈ {s_idle, s_upper, s_lower}
  - `gnt` (cw bits): current winner
  - `ptr` (cw bits): last fully sent channel
  - `p_data`, `p_chan`, `p_half`
- `p_srdy = (state != s_idle)`. It is decoded from registered state only and has no combinational path from `c_srdy`.
- Arbitration is combinational over `c_srdy`. Search order is `ptr+1, ptr+2, …` modulo `inputs`, and the first asserted channel wins. `ptr` is never the top priority unless it is the only requester.
- Sources obey srdy/drdy rules: `c_srdy` and `c_data` stay stable from assertion until `c_drdy` for that channel. The block does not copy the lower half until the upper beat is accepted.
- **s_idle**:
  - `c_drdy = 0`.
  - If any `c_srdy`: `gnt` ← winner; `p_data` ← `c_data[winner]` upper half; `p_chan` ← winner; `p_half` ← 1; go to s_upper.
- **s_upper**:
  - If `p_drdy`: `c_drdy[gnt] = 1` (same cycle, combinational from `p_drdy`); `p_data` ← `c_data[gnt]` lower half; `p_half` ← 0; go to s_lower.
  - Else hold all registers; `c_drdy = 0`.
- **s_lower**:
  - `c_drdy = 0`.
  - If `p_drdy`: `ptr` ← `gnt`. Then:
    - If any `c_srdy`, arbitrate using the updated `ptr` (that is, searching from `gnt+1`), load the new winner's upper half and go to s_upper.
    - Otherwise go to s_idle.
  - Else hold.
- Channel ids (`cw` bits) wrap modulo `inputs`. When `inputs` is not a power of two, ids ≥ `inputs` are never generated.
- An unreachable or illegal state encoding returns to s_idle.

## Timing
- Reset values:
  - `state` = s_idle; `ptr` = `inputs-1`, so channel 0 has first priority after reset.
  - `gnt` = 0; `p_chan` = 0; `p_half` = 0.
  - `p_srdy` = 0; `c_drdy` = 0.
  - `p_data` is not reset; its value is don't-care while `p_srdy` = 0.
- Reset asserted mid-token (in s_upper or s_lower) abandons the token: next cycle is s_idle with reset values, and no `c_drdy` fires.
- Latency: `c_srdy` seen in s_idle at edge N gives the upper beat valid from cycle N+1.
- Throughput with `p_drdy` held high and requesters always ready: one beat per cycle, no idle bubble between tokens, 2 cycles per token.
- `c_drdy[k]` is a single-cycle pulse per token, asserted in the cycle the upper beat is accepted.
- Backpressure: while `p_drdy` = 0, `p_data`, `p_chan` and `p_half` are held constant.
- A new `c_srdy` on a lower-priority channel during s_upper or s_lower does not preempt; the grant is held until the lower beat is accepted.
- Same channel back-to-back: if only `gnt` requests at the end of s_lower, it is re-granted immediately.

## Test plan
- **Single token.** After reset, `inputs=2`, `width=8`; ch0 `c_srdy`=1, `c_data`=0xA5, `p_drdy`=1. Required: cycle 1 beat `p_data`=0xA, `p_chan`=0, `p_half`=1; cycle 2 beat 0x5 with `p_half`=0 and `c_drdy`=01 in cycle 1 only; s_idle in cycle 3.
- **Round-robin fairness.** ch0 and ch1 continuously requesting (ch0=0x12, ch1=0x34), `p_drdy`=1. Required beats in order: 1,2,3,4,1,2,…; `p_chan` sequence 0,0,1,1,0,0; no bubbles.
- **Backpressure.** ch1 sends 0xC3 with `p_drdy`=0 for 3 cycles in s_upper, then 2 cycles in s_lower. Required: `p_data` holds 0xC, then 0x3; `p_chan`=1 constant; exactly one `c_drdy[1]` pulse.
- **Late requester, `inputs=3`.** Grant ch1; ch0 and ch2 assert mid-token. Required: ch1 completes uninterrupted, then ch2, then ch0.
- **Reset mid-operation.** Assert `reset` during s_lower of a ch0 token. Required: next cycle `p_srdy`=0 and `c_drdy`=0; after release, ch0 wins first again.
- **Idle gap.** Requests stop after the lower beat. Required: `p_srdy`=0 the following cycle; a request 3 cycles later yields the upper beat one cycle after it.
